// File: rtl/test_dout_src_pkg.sv
// Shared types and helpers for the test_dout_src pattern source.
// Optional LFSR mode is selected with the TEST_DOUT_SRC_LFSR_EN macro.
package test_dout_src_pkg;

    // Source FSM states, 2-bit encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // Width of the emitted-beat counter
    localparam int unsigned BEAT_CNT_W = 32;

    // Widest LFSR the helper function supports
    localparam int unsigned LFSR_MAX_W = 64;

    // One Galois LFSR step. Operands are zero-extended by the caller, so the
    // right shift feeds zeros into the unused upper bits.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] value,
        input logic [LFSR_MAX_W-1:0] poly
    );
        return (value >> 1) ^ (value[0] ? poly : '0);
    endfunction

endpackage

// File: rtl/test_dout_src_lfsr.sv
// Combinational Galois LFSR next-value for test_dout_src.
// Instantiated only when TEST_DOUT_SRC_LFSR_EN is defined.
module test_dout_src_lfsr
    import test_dout_src_pkg::*;
#(
    parameter int unsigned         DWIDTH = 16,
    parameter logic [DWIDTH-1:0]   POLY   = DWIDTH'(16'hB400)
) (
    input  logic [DWIDTH-1:0] value,
    output logic [DWIDTH-1:0] next
);

    // Single LFSR step, truncated back to the data width
    always_comb begin
        next = DWIDTH'(lfsr_next(LFSR_MAX_W'(value), LFSR_MAX_W'(POLY)));
    end

endmodule

// File: rtl/test_dout_src.sv
// Autonomous registered stream source (counter or LFSR pattern).
// Define TEST_DOUT_SRC_LFSR_EN to replace the adder with a Galois LFSR.
module test_dout_src
    import test_dout_src_pkg::*;
#(
    parameter int unsigned         DWIDTH = 16,
    parameter logic [DWIDTH-1:0]   START  = '0,
    parameter logic [DWIDTH-1:0]   STEP   = DWIDTH'(1),
    parameter int unsigned         GAP    = 0,
    parameter int unsigned         COUNT  = 0,
    parameter logic [DWIDTH-1:0]   POLY   = DWIDTH'(16'hB400)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              dout_valid,
    output logic [DWIDTH-1:0] dout_data
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_SEND = SEND;
    localparam logic [1:0] ST_WAIT = WAIT;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic                  emit;
    logic [DWIDTH-1:0]     next_val;
    logic [DWIDTH-1:0]     adv_val;
    logic [BEAT_CNT_W-1:0] beat_cnt;
    logic [BEAT_CNT_W-1:0] beat_inc;
    logic [31:0]           gap_cnt;

`ifdef TEST_DOUT_SRC_LFSR_EN
    // An all-zero seed would lock the LFSR, so START=0 seeds with 1
    localparam logic [DWIDTH-1:0] SEED = (START == '0) ? DWIDTH'(1) : START;

    test_dout_src_lfsr #(
        .DWIDTH (DWIDTH),
        .POLY   (POLY)
    ) u_lfsr (
        .value (next_val),
        .next  (adv_val)
    );
`else
    localparam logic [DWIDTH-1:0] SEED = START;

    // Counter-mode advance, wrapping modulo 2^DWIDTH
    always_comb begin
        adv_val = next_val + STEP;
    end
`endif

    // Saturating beat count so infinite runs never wrap
    always_comb begin
        beat_inc = (beat_cnt == '1) ? beat_cnt : beat_cnt + 1'b1;
    end

    // Next-state and beat-emission decision
    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        case (state)
            ST_IDLE: begin
                state_nxt = ST_SEND;
                emit      = 1'b1;
            end
            ST_SEND: begin
                if (COUNT != 0 && beat_cnt == COUNT) begin
                    state_nxt = ST_DONE;
                end else if (GAP == 0) begin
                    emit = 1'b1;
                end else begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Emitting on the last idle cycle gives exactly GAP idle cycles
                if (gap_cnt == 32'd1) begin
                    state_nxt = ST_SEND;
                    emit      = 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_DONE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered outputs, value generator, beat and gap counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            dout_valid <= 1'b0;
            dout_data  <= '0;
            next_val   <= SEED;
            beat_cnt   <= '0;
            gap_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            dout_valid <= emit;
            if (emit) begin
                dout_data <= next_val;
                next_val  <= adv_val;
                beat_cnt  <= beat_inc;
            end
            if (state == ST_SEND && state_nxt == ST_WAIT) begin
                gap_cnt <= 32'(GAP);
            end else if (state == ST_WAIT) begin
                gap_cnt <= gap_cnt - 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_test_dout_src.sv
// Self-checking bench for test_dout_src: five differently configured
// instances checked every cycle against a timing/value reference model,
// plus a fixed vector table and hand-written reset sequences.
module tb_test_dout_src;

    logic        clk = 1'b0;
    logic [4:0]  r;
    logic [4:0]  v;
    logic [15:0] d [5];

    always #5 clk = ~clk;

    localparam logic [15:0] P_START [5] = '{16'h0000, 16'h0005, 16'hFFFE, 16'h0100, 16'h1234};
    localparam logic [15:0] P_STEP  [5] = '{16'h0001, 16'h0003, 16'h0001, 16'h0002, 16'h0F0F};
    localparam int unsigned P_GAP   [5] = '{0, 2, 0, 1, 3};
    localparam int unsigned P_COUNT [5] = '{0, 0, 4, 0, 7};

    test_dout_src #(.DWIDTH(16), .START(16'h0000), .STEP(16'h0001), .GAP(0), .COUNT(0), .POLY(16'hB400))
        u0 (.clk(clk), .rst(r[0]), .dout_valid(v[0]), .dout_data(d[0]));
    test_dout_src #(.DWIDTH(16), .START(16'h0005), .STEP(16'h0003), .GAP(2), .COUNT(0), .POLY(16'hB400))
        u1 (.clk(clk), .rst(r[1]), .dout_valid(v[1]), .dout_data(d[1]));
    test_dout_src #(.DWIDTH(16), .START(16'hFFFE), .STEP(16'h0001), .GAP(0), .COUNT(4), .POLY(16'hB400))
        u2 (.clk(clk), .rst(r[2]), .dout_valid(v[2]), .dout_data(d[2]));
    test_dout_src #(.DWIDTH(16), .START(16'h0100), .STEP(16'h0002), .GAP(1), .COUNT(0), .POLY(16'hB400))
        u3 (.clk(clk), .rst(r[3]), .dout_valid(v[3]), .dout_data(d[3]));
    test_dout_src #(.DWIDTH(16), .START(16'h1234), .STEP(16'h0F0F), .GAP(3), .COUNT(7), .POLY(16'hB400))
        u4 (.clk(clk), .rst(r[4]), .dout_valid(v[4]), .dout_data(d[4]));

    typedef struct {
        int          id;
        int unsigned n;
        logic        valid;
        logic [15:0] data;
    } vec_t;

    vec_t        tbl [$];
    int unsigned n_rel [5];
    int unsigned hold [5];
    int          checks;
    int          failures;
    bit          phase_a;

    // Value of the k-th beat (k from 0)
    function automatic logic [15:0] ref_val(input int id, input int unsigned k);
`ifdef TEST_DOUT_SRC_LFSR_EN
        logic [15:0] x;
        x = (P_START[id] == 16'h0) ? 16'h0001 : P_START[id];
        for (int unsigned i = 0; i < k; i++) begin
            x = {1'b0, x[15:1]} ^ (x[0] ? 16'hB400 : 16'h0000);
        end
        return x;
`else
        return 16'(32'(P_START[id]) + k * 32'(P_STEP[id]));
`endif
    endfunction

    // Expected outputs n edges after reset release (n=0: in reset)
    task automatic model(input int id, input int unsigned n, output logic ev, output logic [15:0] ed);
        int unsigned k;
        int unsigned ph;
        if (n == 0) begin
            ev = 1'b0;
            ed = 16'h0000;
        end else begin
            k  = (n - 1) / (P_GAP[id] + 1);
            ph = (n - 1) % (P_GAP[id] + 1);
            if (P_COUNT[id] != 0 && k >= P_COUNT[id]) begin
                ev = 1'b0;
                ed = ref_val(id, P_COUNT[id] - 1);
            end else begin
                ev = (ph == 0);
                ed = ref_val(id, k);
            end
        end
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // One clock: track edges since release, then compare at the falling edge
    task automatic step();
        logic        ev;
        logic [15:0] ed;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            if (r[i]) n_rel[i] = 0;
            else if (n_rel[i] != 32'hFFFF_FFFF) n_rel[i]++;
        end
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            model(i, n_rel[i], ev, ed);
            check($sformatf("model_valid%0d_n%0d", i, n_rel[i]), 16'(v[i]), 16'(ev));
            check($sformatf("model_data%0d_n%0d", i, n_rel[i]), d[i], ed);
        end
        if (phase_a) begin
            foreach (tbl[j]) begin
                if (n_rel[tbl[j].id] == tbl[j].n) begin
                    check($sformatf("tbl_valid%0d_n%0d", tbl[j].id, tbl[j].n), 16'(v[tbl[j].id]), 16'(tbl[j].valid));
                    check($sformatf("tbl_data%0d_n%0d", tbl[j].id, tbl[j].n), d[tbl[j].id], tbl[j].data);
                end
            end
        end
    endtask

    initial begin
        r        = '1;
        checks   = 0;
        failures = 0;
        phase_a  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_rel[i] = 0;
            hold[i]  = 0;
        end

`ifdef TEST_DOUT_SRC_LFSR_EN
        tbl.push_back('{0, 1, 1'b1, 16'h0001});
        tbl.push_back('{0, 2, 1'b1, 16'hB400});
        tbl.push_back('{0, 3, 1'b1, 16'h5A00});
`else
        tbl.push_back('{0, 1, 1'b1, 16'h0000});
        tbl.push_back('{0, 2, 1'b1, 16'h0001});
        tbl.push_back('{0, 4, 1'b1, 16'h0003});
        tbl.push_back('{1, 1, 1'b1, 16'h0005});
        tbl.push_back('{1, 2, 1'b0, 16'h0005});
        tbl.push_back('{1, 3, 1'b0, 16'h0005});
        tbl.push_back('{1, 4, 1'b1, 16'h0008});
        tbl.push_back('{1, 7, 1'b1, 16'h000B});
        tbl.push_back('{1, 8, 1'b0, 16'h000B});
        tbl.push_back('{2, 1, 1'b1, 16'hFFFE});
        tbl.push_back('{2, 2, 1'b1, 16'hFFFF});
        tbl.push_back('{2, 3, 1'b1, 16'h0000});
        tbl.push_back('{2, 4, 1'b1, 16'h0001});
        tbl.push_back('{2, 5, 1'b0, 16'h0001});
        tbl.push_back('{2, 12, 1'b0, 16'h0001});
`endif

        // Reset for 3 cycles, then release everything together
        repeat (3) step();
        r       = '0;
        phase_a = 1'b1;
        repeat (20) step();
        phase_a = 1'b0;

        // Reset landing on the 3rd beat of the GAP=1 instance
        r[3] = 1'b1;
        repeat (2) step();
        r[3] = 1'b0;
        for (int c = 0; c < 30 && n_rel[3] != 5; c++) step();
        check("wait_third_beat", 16'(n_rel[3]), 16'd5);
        check("third_beat_valid", 16'(v[3]), 16'd1);
        check("third_beat_data", d[3], ref_val(3, 2));
        r[3] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            check($sformatf("rst_hold_valid_c%0d", c), 16'(v[3]), 16'd0);
            check($sformatf("rst_hold_data_c%0d", c), d[3], 16'h0000);
        end
        r[3] = 1'b0;
        step();
        check("restart_valid", 16'(v[3]), 16'd1);
        check("restart_data", d[3], ref_val(3, 0));

        // Random reset pulses on every instance
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 5; i++) begin
                if (hold[i] > 0) begin
                    r[i] = 1'b1;
                    hold[i]--;
                end else begin
                    r[i] = 1'b0;
                    if ($urandom_range(0, 59) == 0) hold[i] = $urandom_range(1, 4);
                end
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
